// File: rtl/kbd_mouse_decoder_if.sv
// ---------------------------------------------------------------------------
// kbd_mouse_decoder_if
// Purpose : bundles the strobed keyboard/mouse event stream coming from the
//           SPI user-IO block together with the keycode valid/ack handshake
//           towards the keyboard serialiser.
// Signals :
//   kms_strobe  event valid, one clk_sys cycle per event
//   kms_type    0=mouse x, 1=mouse y/wheel, 2=keycode, 3=OSD key
//   kms_data    event payload (two's-complement delta for mouse events)
//   mouse_idx   mouse select for mouse events
//   key_valid   keycode FIFO head is valid
//   key_data    keycode FIFO head
//   key_ack     consumer pops the head
// Modports:
//   master  event source / keycode consumer side (drives events and ack)
//   slave   the decoder (receives events, presents the FIFO head)
// ---------------------------------------------------------------------------
interface kbd_mouse_decoder_if;
  logic       kms_strobe;
  logic [1:0] kms_type;
  logic [7:0] kms_data;
  logic       mouse_idx;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ack;

  modport master (
    output kms_strobe, kms_type, kms_data, mouse_idx, key_ack,
    input  key_valid, key_data
  );

  modport slave (
    input  kms_strobe, kms_type, kms_data, mouse_idx, key_ack,
    output key_valid, key_data
  );
endinterface

// File: rtl/kbd_mouse_decoder.sv
// ---------------------------------------------------------------------------
// kbd_mouse_decoder
// Purpose : decodes the keyboard/mouse event stream of the SPI user-IO block
//           (clk_sys domain). Mouse x/y/wheel deltas are accumulated into
//           8-bit wrapping position counters for two mice; keycodes are
//           buffered in a FIFO read through a valid/ack handshake.
// Parameters:
//   FIFO_DEPTH  keycode FIFO entries, power of two, 2..64
//   INVERT_Y    1: y counter subtracts the delta instead of adding it
// Optional feature macro: MOUSE_WHEEL_EN
//   defined   : third mouse event of an x/y/wheel group updates the wheel
//               counter of the latched mouse
//   undefined : wheel event is consumed, wheel outputs tied to 0
// Ports:
//   clk_sys        system clock
//   reset          synchronous active-high reset
//   kms            event stream + keycode handshake (slave modport)
//   mouse0_x/_y    mouse 0 position counters
//   mouse1_x/_y    mouse 1 position counters
//   mouse0_wheel   mouse 0 wheel counter
//   mouse1_wheel   mouse 1 wheel counter
//   kbd_overflow   sticky flag, a keycode was dropped on a full FIFO
//   overflow_clr   clears kbd_overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module kbd_mouse_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int INVERT_Y   = 0
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  kbd_mouse_decoder_if.slave    kms,
  output logic [7:0]            mouse0_x,
  output logic [7:0]            mouse0_y,
  output logic [7:0]            mouse1_x,
  output logic [7:0]            mouse1_y,
  output logic [7:0]            mouse0_wheel,
  output logic [7:0]            mouse1_wheel,
  output logic                  kbd_overflow,
  input  logic                  overflow_clr
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_X = 2'd1,
    GOT_Y = 2'd2
  } seq_state_e;

  // ---------------- mouse sequencer and counters ----------------
  seq_state_e state_q, state_d;
  logic       cur_q, cur_d;
  logic [7:0] mx_q [2];
  logic [7:0] mx_d [2];
  logic [7:0] my_q [2];
  logic [7:0] my_d [2];
`ifdef MOUSE_WHEEL_EN
  logic [7:0] mw_q [2];
  logic [7:0] mw_d [2];
`endif

  // Sequencer next state and counter updates; 8-bit adds give modulo-256
  // wrap, and truncating the add is the same as adding the sign-extended delta.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    mx_d    = mx_q;
    my_d    = my_q;
`ifdef MOUSE_WHEEL_EN
    mw_d    = mw_q;
`endif
    if (kms.kms_strobe) begin
      case (kms.kms_type)
        2'd0: begin
          mx_d[kms.mouse_idx] = mx_q[kms.mouse_idx] + kms.kms_data;
          cur_d               = kms.mouse_idx;
          state_d             = GOT_X;
        end
        2'd1: begin
          case (state_q)
            GOT_X: begin
              if (INVERT_Y != 0) begin
                my_d[cur_q] = my_q[cur_q] - kms.kms_data;
              end else begin
                my_d[cur_q] = my_q[cur_q] + kms.kms_data;
              end
              state_d = GOT_Y;
            end
            GOT_Y: begin
`ifdef MOUSE_WHEEL_EN
              mw_d[cur_q] = mw_q[cur_q] + kms.kms_data;
`endif
              state_d = IDLE;
            end
            IDLE:    state_d = IDLE;  // orphan y, ignored
            default: state_d = IDLE;
          endcase
        end
        default: state_d = IDLE;      // keycode / OSD key break a mouse group
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer and counter registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q   <= 1'b0;
      mx_q    <= '{8'd0, 8'd0};
      my_q    <= '{8'd0, 8'd0};
`ifdef MOUSE_WHEEL_EN
      mw_q    <= '{8'd0, 8'd0};
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
`ifdef MOUSE_WHEEL_EN
      mw_q    <= mw_d;
`endif
    end
  end

  assign mouse0_x = mx_q[0];
  assign mouse0_y = my_q[0];
  assign mouse1_x = mx_q[1];
  assign mouse1_y = my_q[1];
`ifdef MOUSE_WHEEL_EN
  assign mouse0_wheel = mw_q[0];
  assign mouse1_wheel = mw_q[1];
`else
  assign mouse0_wheel = 8'd0;
  assign mouse1_wheel = 8'd0;
`endif

  // ---------------- keycode FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] kept_s;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_data_q, key_data_d;
  logic          ovf_q, ovf_d;
  logic          pop_s, push_s, full_s, push_acc_s, drop_s;

  // FIFO control. The head is kept in a register: next head is the pushed
  // byte when the FIFO would otherwise be empty (nothing left after the pop),
  // else the entry at the post-pop read pointer.
  always_comb begin
    pop_s      = key_valid_q & kms.key_ack;
    push_s     = kms.kms_strobe & (kms.kms_type == 2'd2);
    full_s     = (count_q == DEPTH_C);
    push_acc_s = push_s & (~full_s | pop_s);
    drop_s     = push_s & full_s & ~pop_s;
    kept_s     = count_q - {{(CW-1){1'b0}}, pop_s};
    count_d    = kept_s + {{(CW-1){1'b0}}, push_acc_s};
    rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, pop_s};
    wr_ptr_d   = wr_ptr_q + {{(AW-1){1'b0}}, push_acc_s};
    key_valid_d = (count_d != {CW{1'b0}});
    if (count_d == {CW{1'b0}}) begin
      key_data_d = 8'd0;
    end else if (kept_s == {CW{1'b0}}) begin
      key_data_d = kms.kms_data;
    end else begin
      key_data_d = mem_q[rd_ptr_d];
    end
    // a drop in the same cycle as a clear leaves the flag set
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage; contents are don't-care until referenced by the pointers.
  always_ff @(posedge clk_sys) begin
    if (push_acc_s) begin
      mem_q[wr_ptr_q] <= kms.kms_data;
    end
  end

  // FIFO pointers, head register and overflow flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_ptr_q    <= {AW{1'b0}};
      wr_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      key_valid_q <= 1'b0;
      key_data_q  <= 8'd0;
      ovf_q       <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      key_valid_q <= key_valid_d;
      key_data_q  <= key_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign kms.key_valid = key_valid_q;
  assign kms.key_data  = key_data_q;
  assign kbd_overflow  = ovf_q;

endmodule

// File: tb/tb_kbd_mouse_decoder.sv
// Scoreboard bench for kbd_mouse_decoder: the driver computes expectations
// from a position/queue model and queues them; the monitor compares them
// against the DUT half a cycle after each event edge or keycode pop.
module tb_kbd_mouse_decoder;
  localparam int DEPTH = 8;
  localparam int INV   = 0;

  logic clk = 1'b0;
  logic reset;
  logic overflow_clr;
  logic [7:0] m0x, m0y, m1x, m1y, m0w, m1w;
  logic kbd_overflow;

  kbd_mouse_decoder_if ifc();

  kbd_mouse_decoder #(.FIFO_DEPTH(DEPTH), .INVERT_Y(INV)) dut (
    .clk_sys(clk), .reset(reset), .kms(ifc.slave),
    .mouse0_x(m0x), .mouse0_y(m0y), .mouse1_x(m1x), .mouse1_y(m1y),
    .mouse0_wheel(m0w), .mouse1_wheel(m1w),
    .kbd_overflow(kbd_overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] x0, y0, x1, y1, w0, w1;
    logic       ovf, kv;
  } exp_t;

  exp_t       mq[$];      // expected mouse/flag state after each event
  logic [7:0] kq[$];      // expected keycodes, in pop order
  logic [7:0] mf[$];      // model of the FIFO contents
  int px[2], py[2], pw[2];
  int phase;              // 0 none, 1 after x, 2 after y
  bit cur;
  bit m_ovf;
  int errors = 0;
  int checks = 0;
  logic [7:0] last_pop = 8'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and advance the model past the next edge.
  task automatic drive(input bit stb, input logic [1:0] ty, input logic [7:0] d,
                       input bit idx, input bit ack, input bit clr);
    int  sz;
    bit  pop, drop;
    int  s;
    exp_t e;
    ifc.kms_strobe = stb; ifc.kms_type = ty; ifc.kms_data = d;
    ifc.mouse_idx = idx;  ifc.key_ack = ack; overflow_clr = clr;
    sz = mf.size();
    pop = ack && (sz > 0);
    drop = 1'b0;
    if (pop) kq.push_back(mf.pop_front());
    if (stb && ty == 2'd2) begin
      if (sz == DEPTH && !pop) drop = 1'b1;
      else mf.push_back(d);
    end
    if (clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    if (stb) begin
      s = int'($signed(d));
      case (ty)
        2'd0: begin px[idx] += s; cur = idx; phase = 1; end
        2'd1: begin
          if (phase == 1) begin
            if (INV != 0) py[cur] -= s; else py[cur] += s;
            phase = 2;
          end else if (phase == 2) begin
`ifdef MOUSE_WHEEL_EN
            pw[cur] += s;
`endif
            phase = 0;
          end
        end
        default: phase = 0;
      endcase
      e.x0 = 8'(px[0]); e.y0 = 8'(py[0]); e.x1 = 8'(px[1]); e.y1 = 8'(py[1]);
      e.w0 = 8'(pw[0]); e.w1 = 8'(pw[1]);
      e.ovf = m_ovf; e.kv = (mf.size() > 0);
      mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit ack);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 8'd0, 1'b0, ack, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.kms_strobe = 1'b0; ifc.kms_type = 2'd0; ifc.kms_data = 8'd0;
    ifc.mouse_idx = 1'b0; ifc.key_ack = 1'b0; overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mf.delete();
    px = '{0, 0}; py = '{0, 0}; pw = '{0, 0};
    phase = 0; cur = 1'b0; m_ovf = 1'b0;
  endtask

  // Monitor: remember whether an event was sampled at this edge.
  bit prev_stb = 1'b0;
  always @(posedge clk) prev_stb = ifc.kms_strobe && !reset;

  // Monitor: compare queued expectations half a cycle after the edge.
  exp_t mon_e;
  always @(negedge clk) begin
    if (prev_stb) begin
      if (mq.size() == 0) begin
        checks++; errors++;
        $display("FAIL mouse_q: got event with no expectation queued");
      end else begin
        mon_e = mq.pop_front();
        chk("mouse0_x", m0x, mon_e.x0);
        chk("mouse0_y", m0y, mon_e.y0);
        chk("mouse1_x", m1x, mon_e.x1);
        chk("mouse1_y", m1y, mon_e.y1);
        chk("mouse0_wheel", m0w, mon_e.w0);
        chk("mouse1_wheel", m1w, mon_e.w1);
        chk("kbd_overflow", {7'd0, kbd_overflow}, {7'd0, mon_e.ovf});
        chk("key_valid", {7'd0, ifc.key_valid}, {7'd0, mon_e.kv});
      end
    end
    if (!reset && ifc.key_valid && ifc.key_ack) begin
      if (kq.size() == 0) begin
        checks++; errors++;
        $display("FAIL key_pop: got %02h with no keycode expected", ifc.key_data);
      end else begin
        chk("key_data", ifc.key_data, kq.pop_front());
      end
      last_pop = ifc.key_data;
    end
  end

  initial begin
    do_reset();
    chk("rst_m0x", m0x, 8'd0); chk("rst_m1y", m1y, 8'd0);
    chk("rst_m0w", m0w, 8'd0);
    chk("rst_kv", {7'd0, ifc.key_valid}, 8'd0);
    chk("rst_kd", ifc.key_data, 8'd0);
    chk("rst_ovf", {7'd0, kbd_overflow}, 8'd0);

    // mouse 0 x/y
    drive(1'b1, 2'd0, 8'h05, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 8'hFD, 1'b0, 1'b0, 1'b0);
    chk("dir_m0x", m0x, 8'h05);
    chk("dir_m0y", m0y, (INV != 0) ? 8'h03 : 8'hFD);
    chk("dir_m1x", m1x, 8'h00);

    // mouse 1 wrap
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd0, 8'h7F, 1'b1, 1'b0, 1'b0);
    chk("wrap_m1x", m1x, 8'h7D);
    drive(1'b1, 2'd1, 8'h02, 1'b1, 1'b0, 1'b0);
    chk("wrap_m1y", m1y, (INV != 0) ? 8'hFE : 8'h02);

    // x, y, wheel
    do_reset();
    drive(1'b1, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 8'h02, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 8'h01, 1'b0, 1'b0, 1'b0);
    chk("whl_m0y", m0y, (INV != 0) ? 8'hFE : 8'h02);
`ifdef MOUSE_WHEEL_EN
    chk("whl_m0w", m0w, 8'h01);
`else
    chk("whl_m0w", m0w, 8'h00);
`endif
    // orphan y after the group ended, then OSD key
    drive(1'b1, 2'd1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("orphan_m0y", m0y, (INV != 0) ? 8'hFE : 8'h02);
    drive(1'b1, 2'd3, 8'h45, 1'b0, 1'b0, 1'b0);
    chk("osd_kv", {7'd0, ifc.key_valid}, 8'd0);

    // overflow: 9 keys into depth 8
    for (int i = 0; i < 9; i++) drive(1'b1, 2'd2, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {7'd0, kbd_overflow}, 8'd1);
    chk("ovf_head", ifc.key_data, 8'h10);
    idle(8, 1'b1);
    chk("ovf_last", last_pop, 8'h17);
    chk("ovf_empty", {7'd0, ifc.key_valid}, 8'd0);
    idle(1, 1'b0);
    drive(1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", {7'd0, kbd_overflow}, 8'd0);

    // full FIFO plus push with simultaneous ack
    for (int i = 0; i < 8; i++) drive(1'b1, 2'd2, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 8'h20, 1'b0, 1'b1, 1'b0);
    chk("fullack_ovf", {7'd0, kbd_overflow}, 8'd0);
    idle(8, 1'b1);
    chk("fullack_last", last_pop, 8'h20);
    chk("fullack_kv", {7'd0, ifc.key_valid}, 8'd0);

    // empty FIFO, push with ack: ack ignored
    drive(1'b1, 2'd2, 8'h5A, 1'b0, 1'b1, 1'b0);
    chk("emptyack_kv", {7'd0, ifc.key_valid}, 8'd1);
    chk("emptyack_kd", ifc.key_data, 8'h5A);
    idle(2, 1'b1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom), ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
    end
    idle(DEPTH + 2, 1'b1);
    idle(1, 1'b0);
    chk("drain_kv", {7'd0, ifc.key_valid}, 8'd0);
    chk("drain_kq", 8'(kq.size()), 8'd0);
    chk("drain_mq", 8'(mq.size()), 8'd0);

    // reset mid-stream
    drive(1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    do_reset();
    chk("midrst_kv", {7'd0, ifc.key_valid}, 8'd0);
    chk("midrst_m0x", m0x, 8'd0);
    drive(1'b1, 2'd1, 8'h04, 1'b0, 1'b0, 1'b0);
    chk("midrst_seq", m0y, 8'd0);
    idle(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
